// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter using double dabble, one bit per clock.
// Produces packed BCD digits, a leading-zero blanking mask and an overflow flag.
module bin_bcd_seq #(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 4,
   parameter int AUTO   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank,
   output logic                  ovf,
   output logic                  busy,
   output logic                  rdy,
   output logic                  done
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);
   localparam logic [CW-1:0]     CNT_LOAD  = CW'(BIN_W);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [BIN_W-1:0]  sreg;
   logic [BIN_W-1:0]  last_bin;
   logic [BIN_W-1:0]  next_sreg;
   logic [BW-1:0]     scratch;
   logic [BW-1:0]     adj;
   logic [BW-1:0]     next_scratch;
   logic [DIGITS-1:0] next_blank;
   logic [CW-1:0]     cnt;
   logic              ovf_acc;
   logic              zero_above;
   logic              trigger;
   logic              last_shift;

   // One double-dabble step: correct digits >= 5, then shift the combined register left.
   // The blank mask is derived from the post-shift digits so it is ready on the final step.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
      next_scratch = {adj[BW-2:0], sreg[BIN_W-1]};
      next_sreg    = {sreg[BIN_W-2:0], 1'b0};
      next_blank   = '0;
      zero_above   = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above    = zero_above & (next_scratch[4*i +: 4] == 4'd0);
         next_blank[i] = zero_above;
      end
   end

   assign trigger    = start | ((AUTO != 0) & (bin != last_bin));
   assign last_shift = (cnt == CW'(1));

   // Control FSM; the result registers only change on the final shift so they hold during SHIFT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sreg     <= '0;
         scratch  <= '0;
         cnt      <= '0;
         last_bin <= '0;
         ovf_acc  <= 1'b0;
         bcd      <= '0;
         blank    <= BLANK_RST;
         ovf      <= 1'b0;
         busy     <= 1'b0;
         rdy      <= 1'b1;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  sreg     <= bin;
                  last_bin <= bin;
                  scratch  <= '0;
                  cnt      <= CNT_LOAD;
                  ovf_acc  <= 1'b0;
                  busy     <= 1'b1;
                  rdy      <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               sreg    <= next_sreg;
               scratch <= next_scratch;
               cnt     <= cnt - CW'(1);
               ovf_acc <= ovf_acc | adj[BW-1];
               if (last_shift) begin
                  bcd   <= next_scratch;
                  blank <= next_blank;
                  ovf   <= ovf_acc | adj[BW-1];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  rdy   <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/bin_bcd_seq.md
BIN_BCD_SEQ -- requirements
Module: bin_bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 12: width of the binary input, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 4: number of BCD output digits, legal range 1..10.
REQ-003 SHALL have parameter AUTO, default 0: 1 means a change of bin, or start, triggers a conversion; 0 means only start triggers one.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state changes occur on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  conversion request; sampled only in IDLE.
REQ-008 bin  in  BIN_W  unsigned binary value to convert.
REQ-009 bcd  out  4*DIGITS  result digits; the most significant digit is in the top nibble.
REQ-010 blank  out  DIGITS  leading-zero mask; bit i is 1 when digit i and every higher digit are zero; bit 0 is always 0.
REQ-011 ovf  out  1  last result exceeded 10^DIGITS-1.
REQ-012 busy  out  1  conversion in progress.
REQ-013 rdy  out  1  high when idle and bcd holds a valid result.
REQ-014 done  out  1  one-cycle pulse marking a new result.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-016 In IDLE, a trigger SHALL capture bin into a shift register, clear the digit scratch, load the bit counter with BIN_W, and move to SHIFT.
- Trigger when AUTO=0: start=1.
- Trigger when AUTO=1: start=1, or bin differs from last_bin.
REQ-017 last_bin SHALL be loaded with the captured value at every capture.
REQ-018 In SHIFT, each cycle SHALL apply double dabble: add 3 to every scratch digit >=5, then shift the whole {scratch, shift register} left by one bit.
REQ-019 SHALL perform exactly BIN_W shift cycles.
REQ-020 On the edge performing the last shift, SHALL load bcd, blank and ovf, set done=1 for one cycle, and return to IDLE.
REQ-021 Latency: capture on edge E0 SHALL give the result and done=1 in the cycle after edge E0+BIN_W.
- busy=1 from after E0 through edge E0+BIN_W.
- rdy=0 over the same interval.
REQ-022 A trigger arriving while in SHIFT SHALL be ignored and not queued; bin changes during SHIFT SHALL not affect the result in progress.
REQ-023 A trigger in the cycle where done=1 SHALL be accepted, giving back-to-back conversions with no dead cycle.
REQ-024 ovf SHALL be set when any 1 bit is shifted out of the top digit during the conversion.
- On overflow, bcd SHALL hold the value mod 10^DIGITS.
- ovf SHALL be cleared at the start of the next conversion's result load.
REQ-025 bcd, blank and ovf SHALL hold the previous result throughout SHIFT.
REQ-026 Input 0 SHALL give bcd=0 and blank = all ones except bit 0.

Reset
REQ-027 On reset, SHALL force: state=IDLE, bcd=0, ovf=0, busy=0, done=0, rdy=1, last_bin=0, blank = all ones except bit 0.
REQ-028 Reset during SHIFT SHALL abort the conversion, discard partial data, and give no done pulse.
REQ-029 With AUTO=1 and bin nonzero at reset release, SHALL trigger a conversion in the first IDLE cycle.

Verification
REQ-030 Defaults: start with bin=100 -> after 12 cycles done=1, bcd=16'h0100, blank=4'b1000, ovf=0.
REQ-031 Defaults: bin=4095 -> bcd=16'h4095, blank=0, ovf=0; busy held exactly 12 cycles.
REQ-032 Start with bin=12, then start with bin=24 five cycles later -> single result 16'h0012; second start ignored; then start with bin=36 in the done cycle -> 16'h0036 exactly 12 cycles later.
REQ-033 AUTO=1: bin changes 0->1024 -> conversion starts with no start pulse, result 16'h1024; bin held constant -> no further done pulses.
REQ-034 DIGITS=3, BIN_W=12: bin=1234 -> bcd=12'h234, ovf=1; next conversion with bin=999 -> ovf=0.
REQ-035 Reset asserted at shift 6 of 12 -> all outputs at reset values immediately; no done pulse; a new start after release converts correctly.
